// File: rtl/coin_acceptor_pkg.sv
// coin_acceptor_pkg: shared coin, controller and detector types plus coin values
package coin_acceptor_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, NICKEL = 2'd1, DIME = 2'd2, QUARTER = 2'd3} coin_t;
  typedef enum logic [1:0] {C_IDLE, C_CREDIT, C_VEND, C_CHANGE} ctrl_state_t;
  typedef enum logic [1:0] {D_IDLE, D_QUAL, D_RELEASE, D_JAM} det_state_t;
  localparam int NICKEL_VAL = 1;
  localparam int DIME_VAL = 2;
  localparam int QUARTER_VAL = 5;
  function automatic int coin_value(coin_t c);
    return c == NICKEL ? NICKEL_VAL : c == DIME ? DIME_VAL : c == QUARTER ? QUARTER_VAL : 0;
  endfunction
  function automatic coin_t decode(logic [2:0] v);
    return v == 3'b001 ? NICKEL : v == 3'b010 ? DIME : v == 3'b100 ? QUARTER : NONE;
  endfunction
endpackage

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: slot sensors and controller-side coin signals
interface coin_acceptor_if #(parameter int DEPTH = 2);
  import coin_acceptor_pkg::*;
  logic sense_n, sense_d, sense_q, enable;
  coin_t deposit, reject;
  logic jam;
  logic [$clog2(DEPTH):0] pending;
  modport master(output sense_n, sense_d, sense_q, enable, input deposit, reject, jam, pending);
  modport slave(input sense_n, sense_d, sense_q, enable, output deposit, reject, jam, pending);
endinterface

// File: rtl/coin_fifo.sv
// coin_fifo: small power-of-two coin buffer with occupancy count
module coin_fifo
  import coin_acceptor_pkg::*;
#(parameter int DEPTH = 2) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  coin_t din,
  output coin_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  coin_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign rd = pop && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign wr = push && (!full || rd);
  assign dout = mem[rp];
  always_ff @(posedge clock) if (wr) mem[wp] <= din;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces slot sensors into coins, buffers and issues them
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int DEPTH = 2,
  parameter int JAM_LIMIT = 15
) (
  input logic clock,
  input logic reset,
  coin_acceptor_if.slave bus
);
  det_state_t state, state_nx;
  logic [2:0] vec, lat, lat_nx, cnt, cnt_nx, low, low_nx;
  logic [7:0] hold, hold_nx;
  logic qual, onehot, full, empty, pop;
  coin_t coin, head;
  logic [$clog2(DEPTH):0] count;
  assign vec = {bus.sense_q, bus.sense_d, bus.sense_n};
  assign onehot = $onehot(vec);
  // the qualifying sample always equals the latched vector, so decode it directly
  assign coin = decode(vec);
  assign pop = bus.enable && !empty;
  always_comb begin
    state_nx = state;
    lat_nx = lat;
    cnt_nx = cnt;
    low_nx = low;
    hold_nx = hold;
    qual = 1'b0;
    case (state)
      D_IDLE:
        if (onehot) begin
          lat_nx = vec;
          cnt_nx = 3'd1;
          qual = DEBOUNCE == 1;
          state_nx = DEBOUNCE == 1 ? D_RELEASE : D_QUAL;
        end else if (vec != 3'b0) state_nx = D_RELEASE;
      D_QUAL:
        if (vec == lat) begin
          cnt_nx = cnt + 3'd1;
          qual = cnt_nx == 3'(DEBOUNCE);
          state_nx = qual ? D_RELEASE : D_QUAL;
        end else state_nx = vec == 3'b0 ? D_IDLE : D_RELEASE;
      D_RELEASE, D_JAM:
        if (vec == 3'b0) begin
          low_nx = low + 3'd1;
          state_nx = low_nx == 3'(DEBOUNCE) ? D_IDLE : state;
        end else begin
          low_nx = 3'd0;
          hold_nx = state == D_RELEASE ? hold + 8'd1 : hold;
          state_nx = state == D_RELEASE && hold_nx == 8'(JAM_LIMIT) ? D_JAM : state;
        end
    endcase
    if (state_nx == D_RELEASE && state != D_RELEASE) begin
      hold_nx = 8'd0;
      low_nx = 3'd0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= D_IDLE;
      lat <= 3'd0;
      cnt <= 3'd0;
      low <= 3'd0;
      hold <= 8'd0;
      bus.deposit <= NONE;
      bus.reject <= NONE;
    end else begin
      state <= state_nx;
      lat <= lat_nx;
      cnt <= cnt_nx;
      low <= low_nx;
      hold <= hold_nx;
      bus.deposit <= pop ? head : NONE;
      bus.reject <= qual && full && !pop ? coin : NONE;
    end
  end
  assign bus.jam = state == D_JAM;
  assign bus.pending = count;
  coin_fifo #(.DEPTH(DEPTH)) fifo (
    .clock(clock),
    .reset(reset),
    .push(qual),
    .pop(pop),
    .din(coin),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: table, directed and randomized checks against a run-length model
module tb_coin_acceptor;
  import coin_acceptor_pkg::*;
  localparam int DEBOUNCE = 3;
  localparam int DEPTH = 2;
  localparam int JAM_LIMIT = 15;
  localparam logic [2:0] VN = 3'b001, VD = 3'b010, VQ = 3'b100, VNQ = 3'b101, V0 = 3'b000;
  typedef struct {
    bit rst;
    bit en;
    logic [2:0] v;
    coin_t dep;
    coin_t rej;
    bit jam;
    logic [1:0] pend;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0, failures = 0;
  int nq, nrej, ndep;
  bit use_model;
  coin_acceptor_if #(.DEPTH(DEPTH)) bus ();
  coin_acceptor #(.DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH), .JAM_LIMIT(JAM_LIMIT)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  coin_t mq[$];
  coin_t e_dep, e_rej;
  int run, zeros, stuck;
  logic [2:0] prev;
  bit locked, jammed;
  function automatic coin_t vcoin(logic [2:0] v);
    case (v)
      3'b001: return NICKEL;
      3'b010: return DIME;
      3'b100: return QUARTER;
      default: return NONE;
    endcase
  endfunction
  // run-length view: a coin is DEBOUNCE identical one-hot samples while armed
  task automatic model(input bit rst, input bit en, input logic [2:0] v);
    coin_t c = NONE;
    if (rst) begin
      mq.delete();
      run = 0; zeros = 0; stuck = 0; prev = 0; locked = 0; jammed = 0;
      e_dep = NONE; e_rej = NONE;
      return;
    end
    if (!locked) begin
      if (v == 0) run = 0;
      else if ($countones(v) != 1 || (run > 0 && v != prev)) begin
        locked = 1; stuck = 0; zeros = 0; run = 0;
      end else begin
        run++;
        if (run == DEBOUNCE) begin
          c = vcoin(v); locked = 1; stuck = 0; zeros = 0; run = 0;
        end
      end
    end else if (v == 0) begin
      zeros++;
      if (zeros == DEBOUNCE) begin locked = 0; jammed = 0; zeros = 0; end
    end else begin
      zeros = 0;
      if (!jammed) begin stuck++; if (stuck == JAM_LIMIT) jammed = 1; end
    end
    prev = v;
    e_dep = NONE;
    if (en && mq.size() > 0) e_dep = mq.pop_front();
    e_rej = NONE;
    if (c != NONE) begin
      if (mq.size() < DEPTH) mq.push_back(c);
      else e_rej = c;
    end
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input bit rst, input bit en, input logic [2:0] v);
    reset = rst;
    bus.enable = en;
    {bus.sense_q, bus.sense_d, bus.sense_n} = v;
    @(posedge clock);
    model(rst, en, v);
    #1;
    if (bus.deposit == QUARTER) nq++;
    if (bus.deposit != NONE) ndep++;
    if (bus.reject != NONE) nrej++;
    if (use_model) begin
      chk("model_deposit", bus.deposit, e_dep);
      chk("model_reject", bus.reject, e_rej);
      chk("model_jam", bus.jam, jammed);
      chk("model_pending", bus.pending, mq.size());
    end
  endtask
  function automatic vec_t r(bit rst, bit en, logic [2:0] v, coin_t dep = NONE, logic [1:0] p = 0);
    return '{rst, en, v, dep, NONE, 1'b0, p};
  endfunction
  initial begin
    vec_t tbl[$];
    tbl.push_back(r(1, 1, V0));
    repeat (2) tbl.push_back(r(0, 1, VD));
    tbl.push_back(r(0, 1, VD, NONE, 1));
    tbl.push_back(r(0, 1, VD, DIME, 0));
    tbl.push_back(r(0, 1, VD));
    repeat (3) tbl.push_back(r(0, 1, V0));
    repeat (2) tbl.push_back(r(0, 1, VN));
    tbl.push_back(r(0, 1, V0));
    repeat (2) tbl.push_back(r(0, 1, VN));
    tbl.push_back(r(0, 1, VN, NONE, 1));
    tbl.push_back(r(0, 1, VN, NICKEL, 0));
    repeat (3) tbl.push_back(r(0, 1, V0));
    repeat (2) tbl.push_back(r(0, 1, VN));
    repeat (3) tbl.push_back(r(0, 1, V0));
    repeat (6) tbl.push_back(r(0, 1, VNQ));
    repeat (3) tbl.push_back(r(0, 1, V0));
    repeat (2) tbl.push_back(r(0, 1, VD));
    tbl.push_back(r(0, 1, VD, NONE, 1));
    tbl.push_back(r(0, 1, V0, DIME, 0));
    repeat (2) tbl.push_back(r(0, 1, V0));
    bus.enable = 1'b0;
    {bus.sense_q, bus.sense_d, bus.sense_n} = 3'b0;
    use_model = 0;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].v);
      chk($sformatf("tbl%0d_deposit", i), bus.deposit, tbl[i].dep);
      chk($sformatf("tbl%0d_reject", i), bus.reject, tbl[i].rej);
      chk($sformatf("tbl%0d_jam", i), bus.jam, tbl[i].jam);
      chk($sformatf("tbl%0d_pending", i), bus.pending, tbl[i].pend);
    end
    use_model = 1;
    // back-pressure: three quarters into a two-deep buffer with enable low
    step(1, 0, V0);
    nrej = 0;
    repeat (3) begin
      repeat (3) step(0, 0, VQ);
      repeat (3) step(0, 0, V0);
    end
    chk("bp_pending", bus.pending, 2);
    chk("bp_reject_pulses", 8'(nrej), 1);
    step(0, 1, V0);
    chk("bp_first", bus.deposit, QUARTER);
    step(0, 1, V0);
    chk("bp_second", bus.deposit, QUARTER);
    step(0, 1, V0);
    chk("bp_drained_dep", bus.deposit, NONE);
    chk("bp_drained_pend", bus.pending, 0);
    // stuck quarter sensor
    step(1, 1, V0);
    nq = 0;
    repeat (25) step(0, 1, VQ);
    chk("stuck_jam_set", bus.jam, 1);
    repeat (3) step(0, 1, V0);
    chk("stuck_jam_clear", bus.jam, 0);
    repeat (5) step(0, 1, V0);
    chk("stuck_one_coin", 8'(nq), 1);
    // reset with one buffered coin and a partial qualification
    step(1, 0, V0);
    repeat (3) step(0, 0, VQ);
    repeat (3) step(0, 0, V0);
    step(0, 0, VD);
    chk("rst_pre_pending", bus.pending, 1);
    step(1, 1, VD);
    chk("rst_deposit", bus.deposit, NONE);
    chk("rst_pending", bus.pending, 0);
    chk("rst_jam", bus.jam, 0);
    ndep = 0;
    repeat (8) step(0, 1, V0);
    chk("rst_no_coin", 8'(ndep), 0);
    // randomized bursts
    step(1, 1, V0);
    for (int n = 0; n < 600; n++) begin
      int kind = $urandom_range(0, 19);
      int len = $urandom_range(1, 6);
      logic [2:0] v;
      case (kind % 10)
        0, 1, 2, 3: v = 3'b000;
        4, 5, 6: v = 3'b001 << $urandom_range(0, 2);
        7: v = 3'($urandom_range(3, 7)) | 3'b011 & 3'b110;
        8: begin v = 3'b001 << $urandom_range(0, 2); len = $urandom_range(14, 22); end
        default: v = 3'($urandom_range(0, 7));
      endcase
      for (int k = 0; k < len; k++) step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage that sits directly upstream of the vending controller.
- Qualifies raw, bouncy slot-sensor pulses (one sensor per coin size) into clean coin events and buffers them in a small FIFO.
- Drives the controller's Coin-typed deposit input, at most one coin per cycle, issued only while the controller's enable is high.
- Coins that cannot be buffered, malformed sensor activity, and stuck sensors are diverted to the return chute or flagged as jam.

Parameters:
- DEBOUNCE, 3: consecutive identical sensor samples required to qualify a coin (range 1..7).
- DEPTH, 2: FIFO entries (power of two, 2..8).
- JAM_LIMIT, 15: cycles a sensor may stay high after qualification before jam is declared (range 1..255).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- sense_n  in  1  raw nickel slot sensor.
- sense_d  in  1  raw dime slot sensor.
- sense_q  in  1  raw quarter slot sensor.
- enable  in  1  from controller; a coin may be issued only when 1.
- deposit  out  2  Coin to controller (NONE=0, NICKEL=1, DIME=2, QUARTER=3); registered.
- reject  out  2  Coin diverted to return chute; one-cycle pulse; registered.
- jam  out  1  sensor-stuck flag; registered.
- pending  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (clock edge with reset=1): detector to IDLE, counters 0, FIFO empty, deposit=NONE, reject=NONE, jam=0, pending=0. Reset mid-qualification discards the partial coin. Reset also discards buffered coins; nothing is issued for them.
- Sensor vector is v={sense_q,sense_d,sense_n}. "One-hot" means exactly one bit set. The candidate coin is decoded from a one-hot v.
- Detector FSM states: IDLE, QUAL, RELEASE, JAM.
  - IDLE: one-hot v -> QUAL, cnt=1, latch candidate. Multi-hot v -> RELEASE, no coin. v=0 -> stay.
  - QUAL, v equal to the latched vector: cnt+1. When cnt+1==DEBOUNCE the coin is qualified; go to RELEASE.
  - QUAL, v==0: glitch; back to IDLE, no coin.
  - QUAL, v any other value: RELEASE, no coin.
  - DEBOUNCE=1 qualifies on the IDLE->QUAL edge itself; go straight to RELEASE.
  - RELEASE: wait for v==0 for DEBOUNCE consecutive cycles, then IDLE. Any v!=0 clears the low-count and increments hold_cnt (cleared on entry). hold_cnt reaching JAM_LIMIT -> JAM.
  - JAM: jam=1. Exit to IDLE after v==0 for DEBOUNCE consecutive cycles; jam drops on that same edge.
- Qualified coin in a given cycle:
  - pushed into the FIFO if not full, counting any pop made in that cycle (pop happens first);
  - otherwise reject=coin for exactly one cycle (next edge) and the FIFO is unchanged.
- Issue: at each edge, if enable==1 and FIFO not empty, deposit<=head and pop; else deposit<=NONE. deposit therefore lags enable by one cycle, matching how the controller samples it. The controller handles a coin arriving after its enable drops, so no retraction is needed.
- A coin qualified in cycle k can appear on deposit at the earliest at edge k+1, i.e. the cycle after the push. There is no bypass around the FIFO.
- Latency from first sensor-high sample to deposit, with FIFO empty and enable=1: DEBOUNCE+1 cycles.
- pending = occupancy after the edge; simultaneous push+pop leaves it unchanged.
- Read/write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy counter saturates by construction; never overflows or underflows.
- In JAM, sensor activity never generates coins. The FIFO keeps draining while jam=1.

Decomposition:
- Shared package holds the Coin and controller State typedefs and the coin nickel-value constants (1/2/5), used by the controller, the environment and the balance monitor.
- Natural sub-module: coin_fifo (parameter DEPTH; push/pop/full/empty/count, same clock and reset). It is instantiated once; the detector FSM and issue logic stay in coin_acceptor.

Test Plan:
- Clean dime, DEBOUNCE=3: sense_d high 5 cycles, enable=1 -> deposit=DIME for exactly one cycle, 4 cycles after sense_d rises; reject stays NONE, pending returns to 0.
- Bounce: sense_n high 2 cycles, low 1, high 4 -> exactly one NICKEL on deposit; a 2-cycle-only pulse produces no coin.
- Multi-hot: sense_n and sense_q high together for 6 cycles -> no deposit, no reject, detector back in IDLE 3 cycles after release.
- Back-pressure, DEPTH=2, enable=0: three qualified quarters -> pending=2, third coin gives reject=QUARTER for one cycle. Then enable=1 -> QUARTER, QUARTER on consecutive cycles.
- Stuck sensor: sense_q held 25 cycles -> one QUARTER deposited, jam=1 at JAM_LIMIT. Release for 3 cycles -> jam=0. No further coin produced.
- Reset with pending=1 and detector in QUAL -> next cycle deposit=NONE, pending=0, jam=0, and no coin is ever issued for either.
